// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module   : rom_arb_pkg
// Purpose  : shared types and constants for the boot-ROM port arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : two-way round-robin arbiter (fetch vs data) with last-grant memory
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_enable,
  input  logic   i_req_fetch,
  input  logic   i_req_data,
  output logic   o_gnt_valid,
  output owner_t o_gnt_owner
);

  owner_t r_last;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    o_gnt_owner = OWN_I;
    if (i_req_fetch && i_req_data) begin
      o_gnt_owner = (r_last == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req_data) begin
      o_gnt_owner = OWN_D;
    end
  end

  assign o_gnt_valid = i_enable && (i_req_fetch || i_req_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= OWN_I;
    end else if (o_gnt_valid) begin
      r_last <= o_gnt_owner;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : shares the boot/instruction ROM read port between I and D paths
// Revision : 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE    = RESET_VECTOR,
  parameter int          ROM_BYTES   = 3500,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy
);

  localparam logic [3:0]  c_wait    = 4'(WAIT_STATES);
  localparam logic [32:0] c_win_end = {1'b0, ROM_BASE} + 33'(ROM_BYTES);

  state_t      r_state;
  state_t      w_state_nxt;
  owner_t      r_owner;
  owner_t      w_gnt_owner;
  logic        w_gnt_valid;
  logic [31:0] r_addr;
  logic [31:0] w_addr_sel;
  logic [3:0]  r_cnt;
  logic        w_addr_ok;
  logic        w_accept;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .i_enable    ((r_state == ST_IDLE) && !reset),
    .i_req_fetch (i_req),
    .i_req_data  (d_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  assign w_accept   = w_gnt_valid;
  assign w_addr_sel = (w_gnt_owner == OWN_D) ? d_addr : i_addr;

  // 33-bit compare so a word near 2^32 cannot wrap back into the window.
  assign w_addr_ok = (w_addr_sel[1:0] == 2'b00)
                  && ({1'b0, w_addr_sel} >= {1'b0, ROM_BASE})
                  && (({1'b0, w_addr_sel} + 33'd4) <= c_win_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_addr_ok ? ST_BUSY : ST_RESP;
      ST_BUSY: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    i_ready  = w_accept && (w_gnt_owner == OWN_I);
    d_ready  = w_accept && (w_gnt_owner == OWN_D);
    i_rvalid = (r_state == ST_RESP) && (r_owner == OWN_I);
    d_rvalid = (r_state == ST_RESP) && (r_owner == OWN_D);
    busy     = (r_state != ST_IDLE);
    rom_addr = (r_state == ST_BUSY) ? r_addr : ROM_BASE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_I;
      r_addr  <= ROM_BASE;
      r_cnt   <= 4'd0;
      i_rdata <= 32'd0;
      i_err   <= 1'b0;
      d_rdata <= 32'd0;
      d_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_owner <= w_gnt_owner;
        r_addr  <= w_addr_sel;
        r_cnt   <= c_wait;
        // Rejected accesses answer immediately and never touch the ROM.
        if (!w_addr_ok) begin
          if (w_gnt_owner == OWN_D) begin
            d_rdata <= 32'd0;
            d_err   <= 1'b1;
          end else begin
            i_rdata <= 32'd0;
            i_err   <= 1'b1;
          end
        end
      end
      if (r_state == ST_BUSY) begin
        if (r_cnt == 4'd0) begin
          if (r_owner == OWN_D) begin
            d_rdata <= rom_data;
            d_err   <= 1'b0;
          end else begin
            i_rdata <= rom_data;
            i_err   <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
